// File: rtl/keypad_entry.sv
// keypad_entry: turns keypad events into a BCD MM:SS entry, a confirmed preset and load/start/err pulses
module keypad_entry #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                keydown_start,
    input  logic                keydown_confirm,
    input  logic                keydown_clear,
    input  logic                keydown_num,
    input  logic [3:0]          num,
    output logic [4*DIGITS-1:0] entry_bcd,
    output logic [2:0]          digit_count,
    output logic [4*DIGITS-1:0] preset_bcd,
    output logic                editing,
    output logic                armed,
    output logic                load,
    output logic                start,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, EDIT, ARMED} state_t;
    localparam int W = 4 * DIGITS;
    localparam logic [2:0] FULL = 3'(DIGITS);
    state_t state_q, state_d;
    logic [W-1:0] entry_d, preset_d;
    logic [2:0] cnt_d;
    logic load_d, start_d, err_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            entry_bcd   <= '0;
            digit_count <= '0;
            preset_bcd  <= '0;
            load        <= 1'b0;
            start       <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_bcd   <= entry_d;
            digit_count <= cnt_d;
            preset_bcd  <= preset_d;
            load        <= load_d;
            start       <= start_d;
            err         <= err_d;
        end
    end
    // Priority chain: clear > confirm > start > num; a losing event is dropped even if the winner is ignored
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_bcd;
        cnt_d    = digit_count;
        preset_d = preset_bcd;
        load_d   = 1'b0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        if (keydown_clear) begin
            state_d = IDLE;
            entry_d = '0;
            cnt_d   = '0;
        end else if (keydown_confirm) begin
            if (state_q == EDIT) begin
                if (entry_bcd[7:4] > 4'd5) begin
                    err_d = 1'b1;
                end else begin
                    preset_d = entry_bcd;
                    load_d   = 1'b1;
                    state_d  = ARMED;
                end
            end
        end else if (keydown_start) begin
            if (state_q == ARMED) begin
                start_d = 1'b1;
                state_d = IDLE;
                entry_d = '0;
                cnt_d   = '0;
            end
        end else if (keydown_num && num <= 4'd9) begin
            if (state_q != EDIT) begin
                entry_d = {{(W-4){1'b0}}, num};
                cnt_d   = 3'd1;
                state_d = EDIT;
            end else if (digit_count < FULL) begin
                entry_d = {entry_bcd[W-5:0], num};
                cnt_d   = digit_count + 3'd1;
            end
        end
    end
    always_comb begin
        editing = state_q == EDIT;
        armed   = state_q == ARMED;
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard of per-event expected outputs plus scenario checks from the keypad_entry behaviour
module tb_keypad_entry;
    logic clk = 1'b0, rst_n = 1'b0;
    logic k_start = 1'b0, k_confirm = 1'b0, k_clear = 1'b0, k_num = 1'b0;
    logic [3:0] num = 4'd0;
    logic [15:0] entry_bcd, preset_bcd;
    logic [2:0] digit_count;
    logic editing, armed, load, start, err;
    int passed = 0, total = 0;

    typedef struct {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] preset;
        logic ed, ar, ld, st, er;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [15:0] m_entry = '0, m_preset = '0;
    int m_cnt = 0, m_state = 0;

    keypad_entry #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .keydown_start(k_start), .keydown_confirm(k_confirm),
        .keydown_clear(k_clear), .keydown_num(k_num), .num(num),
        .entry_bcd(entry_bcd), .digit_count(digit_count), .preset_bcd(preset_bcd),
        .editing(editing), .armed(armed), .load(load), .start(start), .err(err)
    );

    always #5 clk = ~clk;

    // Drive one event for one cycle, advance the model, queue the expected outputs
    task automatic ev(input logic st, input logic cf, input logic cl, input logic nv, input logic [3:0] n);
        exp_t x;
        @(negedge clk);
        k_start = st; k_confirm = cf; k_clear = cl; k_num = nv; num = n;
        x.ld = 0; x.st = 0; x.er = 0;
        if (cl) begin
            m_state = 0; m_entry = '0; m_cnt = 0;
        end else if (cf) begin
            if (m_state == 1 && m_entry[7:4] > 5) x.er = 1;
            else if (m_state == 1) begin m_preset = m_entry; x.ld = 1; m_state = 2; end
        end else if (st) begin
            if (m_state == 2) begin x.st = 1; m_state = 0; m_entry = '0; m_cnt = 0; end
        end else if (nv && n <= 9) begin
            if (m_state != 1) begin m_entry = {12'h000, n}; m_cnt = 1; m_state = 1; end
            else if (m_cnt < 4) begin m_entry = {m_entry[11:0], n}; m_cnt++; end
        end
        x.entry = m_entry; x.cnt = 3'(m_cnt); x.preset = m_preset;
        x.ed = m_state == 1; x.ar = m_state == 2;
        sb.push_back(x);
        @(posedge clk);
        #1;
        k_start = 0; k_confirm = 0; k_clear = 0; k_num = 0; num = 0;
    endtask

    task automatic digit(input logic [3:0] n);
        ev(0, 0, 0, 1, n);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err} !==
                {e.entry, e.cnt, e.preset, e.ed, e.ar, e.ld, e.st, e.er})
                $display("FAIL scoreboard got entry=%h cnt=%0d preset=%h ed=%b ar=%b ld=%b st=%b er=%b exp entry=%h cnt=%0d preset=%h ed=%b ar=%b ld=%b st=%b er=%b",
                         entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err,
                         e.entry, e.cnt, e.preset, e.ed, e.ar, e.ld, e.st, e.er);
            else passed++;
        end
    end

    task automatic test_reset();
        #12;
        total++; if ({entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err} !== 40'h0)
            $display("FAIL reset_state got %h exp 0", {entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err}); else passed++;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_basic();
        digit(1); digit(2); digit(3); digit(0);
        total++; if (entry_bcd !== 16'h1230 || digit_count !== 3'd4) $display("FAIL basic_entry got %h/%0d exp 1230/4", entry_bcd, digit_count); else passed++;
        ev(0, 1, 0, 0, 0);
        total++; if (load !== 1'b1 || preset_bcd !== 16'h1230 || armed !== 1'b1) $display("FAIL basic_confirm got load=%b preset=%h armed=%b exp 1/1230/1", load, preset_bcd, armed); else passed++;
        total++; if (entry_bcd !== 16'h1230 || digit_count !== 3'd4) $display("FAIL basic_kept got %h/%0d exp 1230/4", entry_bcd, digit_count); else passed++;
        ev(0, 0, 0, 0, 0);
        total++; if (load !== 1'b0) $display("FAIL basic_load_width got %b exp 0", load); else passed++;
    endtask

    task automatic test_overflow();
        ev(0, 0, 1, 0, 0);
        digit(9); digit(8); digit(5); digit(9); digit(7);
        total++; if (entry_bcd !== 16'h9859 || digit_count !== 3'd4 || err !== 1'b0) $display("FAIL full_entry got %h/%0d err=%b exp 9859/4/0", entry_bcd, digit_count, err); else passed++;
        ev(0, 1, 0, 0, 0);
        total++; if (load !== 1'b1 || preset_bcd !== 16'h9859) $display("FAIL full_confirm got load=%b preset=%h exp 1/9859", load, preset_bcd); else passed++;
    endtask

    task automatic test_reject();
        ev(0, 0, 1, 0, 0);
        digit(0); digit(7); digit(0);
        ev(0, 1, 0, 0, 0);
        total++; if (err !== 1'b1 || load !== 1'b0 || editing !== 1'b1 || preset_bcd !== 16'h9859) $display("FAIL reject got err=%b load=%b ed=%b preset=%h exp 1/0/1/9859", err, load, editing, preset_bcd); else passed++;
        ev(0, 0, 0, 0, 0);
        total++; if (err !== 1'b0 || entry_bcd !== 16'h0070) $display("FAIL reject_after got err=%b entry=%h exp 0/0070", err, entry_bcd); else passed++;
        ev(0, 0, 1, 0, 0); digit(5); ev(0, 1, 0, 0, 0);
        total++; if (preset_bcd !== 16'h0005 || load !== 1'b1) $display("FAIL reject_retry got preset=%h load=%b exp 0005/1", preset_bcd, load); else passed++;
    endtask

    task automatic test_start();
        ev(0, 0, 1, 0, 0); digit(1); digit(3); digit(0); ev(0, 1, 0, 0, 0);
        ev(1, 0, 0, 0, 0);
        total++; if (start !== 1'b1 || armed !== 1'b0 || editing !== 1'b0 || entry_bcd !== 16'h0 || digit_count !== 3'd0 || preset_bcd !== 16'h0130)
            $display("FAIL start got st=%b ar=%b ed=%b entry=%h cnt=%0d preset=%h exp 1/0/0/0000/0/0130", start, armed, editing, entry_bcd, digit_count, preset_bcd); else passed++;
        ev(1, 0, 0, 0, 0);
        total++; if (start !== 1'b0) $display("FAIL start_again got %b exp 0", start); else passed++;
    endtask

    task automatic test_priority();
        digit(2);
        ev(0, 1, 1, 0, 0);
        total++; if (load !== 1'b0 || editing !== 1'b0 || entry_bcd !== 16'h0) $display("FAIL clear_over_confirm got load=%b ed=%b entry=%h exp 0/0/0", load, editing, entry_bcd); else passed++;
        digit(6);
        ev(0, 1, 0, 1, 4'd4);
        total++; if (load !== 1'b1 || entry_bcd !== 16'h0006 || preset_bcd !== 16'h0006) $display("FAIL confirm_over_num got load=%b entry=%h preset=%h exp 1/0006/0006", load, entry_bcd, preset_bcd); else passed++;
        digit(4'hA);
        total++; if (armed !== 1'b1 || entry_bcd !== 16'h0006 || digit_count !== 3'd1) $display("FAIL bad_digit got ar=%b entry=%h cnt=%0d exp 1/0006/1", armed, entry_bcd, digit_count); else passed++;
        digit(8);
        total++; if (editing !== 1'b1 || entry_bcd !== 16'h0008 || preset_bcd !== 16'h0006) $display("FAIL armed_digit got ed=%b entry=%h preset=%h exp 1/0008/0006", editing, entry_bcd, preset_bcd); else passed++;
    endtask

    task automatic test_async_reset();
        ev(0, 0, 1, 0, 0); digit(4); digit(2);
        @(negedge clk); #2 rst_n = 0; #1;
        total++; if ({entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err} !== 40'h0)
            $display("FAIL async_reset got %h exp 0", {entry_bcd, digit_count, preset_bcd, editing, armed, load, start, err}); else passed++;
        m_state = 0; m_entry = '0; m_cnt = 0; m_preset = '0;
        @(posedge clk); @(negedge clk); rst_n = 1;
        digit(3);
        total++; if (entry_bcd !== 16'h0003 || digit_count !== 3'd1) $display("FAIL after_reset got %h/%0d exp 0003/1", entry_bcd, digit_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_reject();
        test_start();
        test_priority();
        test_async_reset();
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin total++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size()); end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Event consumer for the keypad front end: takes the single-cycle key events (start / confirm / clear / digit) and turns them into a right-aligned BCD MM:SS entry, a confirmed preset, and registered load/start/error pulses for the countdown core. It sits between the keypad block and the countdown timer, on the same clock as the keypad scanner. It validates the entry and owns the editing state machine.

## Interface
- DIGITS, 4, number of BCD digits in the entry (2..7); digit 0 = seconds units, digit 1 = seconds tens, remaining digits are minutes
- clk  in  1  system clock (same clock as keypad scan)
- rst_n  in  1  asynchronous, active-low reset
- keydown_start  in  1  one-cycle pulse, start key pressed
- keydown_confirm  in  1  one-cycle pulse, confirm key pressed
- keydown_clear  in  1  one-cycle pulse, clear key pressed
- keydown_num  in  1  one-cycle pulse, numeric key pressed; value on num
- num  in  4  key value, sampled only when keydown_num=1
- entry_bcd  out  4*DIGITS  digits being typed, right-aligned, zero-filled
- digit_count  out  3  number of digits entered, 0..DIGITS
- preset_bcd  out  4*DIGITS  last accepted preset
- editing  out  1  high in EDIT state
- armed  out  1  high in ARMED state
- load  out  1  one-cycle pulse, preset_bcd just updated
- start  out  1  one-cycle pulse, countdown start request
- err  out  1  one-cycle pulse, confirm rejected

## Operation
- States: IDLE (entry empty), EDIT (≥1 digit typed), ARMED (preset accepted, awaiting start).
- One event acted on per cycle. Priority: clear > confirm > start > num. Lower-priority events in the same cycle are dropped, not queued.
- Digit (keydown_num, num ≤ 9):
  - IDLE or ARMED: entry_bcd = num, digit_count = 1, go to EDIT. In ARMED, preset_bcd is kept.
  - EDIT with digit_count < DIGITS: entry_bcd = {entry_bcd[4*DIGITS-5:0], num}, digit_count +1.
  - EDIT with digit_count = DIGITS: ignored (full). No state change, no err.
- num > 9: ignored in every state.
- Confirm:
  - In EDIT: if entry_bcd[7:4] > 5, pulse err and stay in EDIT with the entry unchanged. Otherwise preset_bcd = entry_bcd, pulse load, go to ARMED. entry_bcd and digit_count are kept, so the display still shows the value.
  - In IDLE or ARMED: ignored.
  - An all-zero entry is accepted.
- Start:
  - In ARMED: pulse start, go to IDLE, entry_bcd = 0, digit_count = 0. preset_bcd is retained.
  - Elsewhere: ignored.
- Clear: from any state go to IDLE, entry_bcd = 0, digit_count = 0. preset_bcd is unchanged. No pulse.

## Timing
- All outputs are registered. A pulse output goes high in the cycle after the event is sampled, for exactly one cycle.
- Data updates land in the same edge as the pulse: preset_bcd changes on the edge that raises load. entry_bcd and digit_count update on the edge after keydown_num is sampled.
- Back-to-back events on consecutive cycles are each processed; throughput is one event per cycle.
- Reset (rst_n low, asynchronous, at any time including mid-entry) forces: state IDLE, entry_bcd = 0, digit_count = 0, preset_bcd = 0, editing = 0, armed = 0, load = 0, start = 0, err = 0. Any in-flight pulse is cancelled.
- After reset deasserts, the first rising edge processes events normally.
- editing and armed are decoded from the state register and are never high together.

## Test plan
- Reset, then digits 1,2,3,0 on consecutive cycles, then confirm -> entry_bcd = 0x1230, digit_count = 4, one load pulse, preset_bcd = 0x1230, armed = 1.
- Five digits 9,8,5,9,7 with DIGITS=4 -> fifth digit ignored, entry_bcd = 0x9859, digit_count = 4; confirm -> load, preset_bcd = 0x9859.
- Entry 0,7,0 then confirm -> err pulse for one cycle, no load, editing = 1, preset_bcd unchanged; then clear, digit 5, confirm -> preset_bcd = 0x0005.
- ARMED with preset 0x0130, start -> start pulse one cycle later, state IDLE, entry_bcd = 0, preset_bcd = 0x0130. A second start is ignored.
- Same-cycle clear + confirm in EDIT -> IDLE, no load. Same-cycle confirm + num=4 -> load only, digit dropped. num = 0xA -> no change.
- Assert rst_n low asynchronously mid-entry (digit_count = 2) between clock edges -> all outputs zero immediately. Hold reset for one edge, release -> digit 3 gives entry_bcd = 0x0003.
